// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared constants and helpers for the logic_unit_pipe block.
//   OPW        - opcode width
//   OP_*       - function select encodings
//   bit_op()   - single-bit gate evaluation used by bitwise_core
package logic_unit_pkg;

    localparam int unsigned OPW = 3;

    localparam logic [OPW-1:0] OP_AND  = 3'b000;
    localparam logic [OPW-1:0] OP_OR   = 3'b001;
    localparam logic [OPW-1:0] OP_XOR  = 3'b010;
    localparam logic [OPW-1:0] OP_NOR  = 3'b011;
    localparam logic [OPW-1:0] OP_NAND = 3'b100;
    localparam logic [OPW-1:0] OP_XNOR = 3'b101;
    localparam logic [OPW-1:0] OP_NOTA = 3'b110;
    localparam logic [OPW-1:0] OP_PASS = 3'b111;

    // One gate per bit lane, same structure as the old 4-bit OR stage.
    function automatic logic bit_op(input logic [OPW-1:0] op, input logic a, input logic b);
        logic r;
        r = a;
        unique case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_NOR:  r = ~(a | b);
            OP_NAND: r = ~(a & b);
            OP_XNOR: r = ~(a ^ b);
            OP_NOTA: r = ~a;
            OP_PASS: r = a;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_pipe_if.sv
// logic_unit_pipe_if: operand/result handshake bundle for logic_unit_pipe.
//   master: operand source and result sink (drives in_*, acc_clr, out_ready)
//   slave : the logic unit (drives in_ready, out_valid, out_y and flags)
interface logic_unit_pipe_if #(
    parameter int unsigned WIDTH = 4
);
    import logic_unit_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [OPW-1:0]   in_op;
    logic             in_acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_zero;
    logic             out_ones;
    logic             out_par;

    modport master (
        output in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
        input  in_ready, out_valid, out_y, out_zero, out_ones, out_par
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
        output in_ready, out_valid, out_y, out_zero, out_ones, out_par
    );

endinterface

// File: rtl/logic_unit_pipe_bitwise_core.sv
// bitwise_core: combinational WIDTH-bit logic function plus status flags.
//   a, b : operands          op  : function select
//   y    : result            zero: y == 0, ones: y all ones, par: XOR of y
module bitwise_core
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   op,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ones,
    output logic             par
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign y[i] = bit_op(op, a[i], b[i]);
    end

    assign zero = ~|y;
    assign ones = &y;
    assign par  = ^y;

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: registered bitwise logic unit with accumulator and
// one-deep valid/ready output stage.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : logic_unit_pipe_if slave (operands, opcode, acc control, result, flags)
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned OPW   = logic_unit_pkg::OPW
) (
    input logic                clk,
    input logic                rst,
    logic_unit_pipe_if.slave   bus
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] y_q;
    logic             valid_q;
    logic             zero_q;
    logic             ones_q;
    logic             par_q;

    logic             accept;
    logic [OPW-1:0]   op;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] y_new;
    logic             zero_new;
    logic             ones_new;
    logic             par_new;

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign op           = bus.in_op;

    // A clear in the same cycle as an accumulate makes the operand zero.
    always_comb begin
        a_eff = bus.in_a;
        if (bus.in_acc) begin
            a_eff = bus.acc_clr ? '0 : acc_q;
        end
    end

    bitwise_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a    (a_eff),
        .b    (bus.in_b),
        .op   (op),
        .y    (y_new),
        .zero (zero_new),
        .ones (ones_new),
        .par  (par_new)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            y_q     <= '0;
            zero_q  <= 1'b1;
            ones_q  <= 1'b0;
            par_q   <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            y_q     <= y_new;
            zero_q  <= zero_new;
            ones_q  <= ones_new;
            par_q   <= par_new;
        end else if (bus.out_ready) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else if (accept && bus.in_acc) begin
            acc_q <= y_new;
        end else if (bus.acc_clr) begin
            acc_q <= '0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_y     = y_q;
    assign bus.out_zero  = zero_q;
    assign bus.out_ones  = ones_q;
    assign bus.out_par   = par_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

    localparam int unsigned W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic_unit_pipe_if #(.WIDTH(W)) bus ();

    logic_unit_pipe #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state
    bit         m_valid = 1'b0;
    logic [W-1:0] m_y   = '0;
    logic [W-1:0] m_acc = '0;
    bit         m_fire  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return a ^ b;
            3: return ~(a | b);
            4: return ~(a & b);
            5: return ~(a ^ b);
            6: return ~a;
            default: return a;
        endcase
    endfunction

    task automatic check_outputs();
        logic [W-1:0] all1;
        all1 = '1;
        check("out_valid", bus.out_valid, m_valid);
        check("out_y", bus.out_y, m_y);
        check("out_zero", bus.out_zero, m_y == 0);
        check("out_ones", bus.out_ones, m_y == all1);
        check("out_par", bus.out_par, $countones(m_y) % 2);
    endtask

    // One clock: check in_ready mid-cycle, advance the model at the edge, check outputs after.
    task automatic tick();
        bit           rdy;
        logic [W-1:0] a_eff;
        @(negedge clk);
        rdy = !m_valid || bus.out_ready;
        check("in_ready", bus.in_ready, rdy);
        @(posedge clk);
        m_fire = bus.in_valid && rdy;
        if (m_fire) begin
            if (bus.in_acc) a_eff = bus.acc_clr ? '0 : m_acc;
            else            a_eff = bus.in_a;
            m_y     = ref_op(int'(bus.in_op), a_eff, bus.in_b);
            m_valid = 1'b1;
            if (bus.in_acc)       m_acc = m_y;
            else if (bus.acc_clr) m_acc = '0;
        end else begin
            if (bus.out_ready) m_valid = 1'b0;
            if (bus.acc_clr)   m_acc = '0;
        end
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input int op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit acc, input bit clr);
        bus.in_valid = v;
        bus.in_op    = op[2:0];
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_acc   = acc;
        bus.acc_clr  = clr;
    endtask

    logic [W-1:0] sweep_exp [8];

    initial begin
        sweep_exp = '{4'b0010, 4'b1110, 4'b1100, 4'b0001,
                      4'b1101, 4'b0011, 4'b0101, 4'b1010};
        drive(0, 0, '0, '0, 0, 0);
        bus.out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check("rst_zero", bus.out_zero, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Opcode sweep, a=1010 b=0110
        for (int op = 0; op < 8; op++) begin
            drive(1, op, 4'b1010, 4'b0110, 0, 0);
            tick();
            check($sformatf("sweep_op%0d", op), bus.out_y, sweep_exp[op]);
            if (op == 1) begin
                check("or_zero", bus.out_zero, 1'b0);
                check("or_ones", bus.out_ones, 1'b0);
                check("or_par", bus.out_par, 1'b1);
            end
        end
        drive(0, 0, '0, '0, 0, 0);
        tick();

        // Stall: OR held for 3 cycles, pending AND not consumed
        bus.out_ready = 1'b0;
        drive(1, 1, 4'b1010, 4'b0110, 0, 0);
        tick();
        drive(1, 0, 4'b1010, 4'b0110, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_ready", bus.in_ready, 1'b0);
            check("stall_y", bus.out_y, 4'b1110);
        end
        bus.out_ready = 1'b1;
        tick();
        check("stall_release_fire", m_fire, 1'b1);
        check("stall_release_y", bus.out_y, 4'b0010);

        // Accumulator chain
        drive(0, 0, '0, '0, 0, 1);
        tick();
        drive(1, 1, '0, 4'b0001, 1, 0); tick(); check("acc1", bus.out_y, 4'b0001);
        drive(1, 1, '0, 4'b0100, 1, 0); tick(); check("acc2", bus.out_y, 4'b0101);
        drive(1, 1, '0, 4'b1000, 1, 0); tick(); check("acc3", bus.out_y, 4'b1101);
        drive(1, 2, '0, 4'b1111, 1, 0); tick(); check("acc_xor", bus.out_y, 4'b0010);

        // Load acc=1100, then clear+accumulate in one cycle
        drive(1, 1, '0, 4'b1100, 1, 1); tick(); check("acc_load", bus.out_y, 4'b1100);
        drive(1, 1, '0, 4'b0011, 1, 1); tick(); check("clr_acc_y", bus.out_y, 4'b0011);
        drive(1, 7, 4'b1111, '0, 1, 0); tick(); check("clr_acc_val", bus.out_y, 4'b0011);

        // Flag corners
        drive(1, 0, 4'b1111, 4'b0000, 0, 0); tick();
        check("and_zero", bus.out_zero, 1'b1);
        check("and_par", bus.out_par, 1'b0);
        drive(1, 5, 4'b0101, 4'b0101, 0, 0); tick();
        check("xnor_y", bus.out_y, 4'b1111);
        check("xnor_ones", bus.out_ones, 1'b1);
        check("xnor_par", bus.out_par, 1'b0);

        // Async reset mid-stall with a loaded accumulator
        bus.out_ready = 1'b0;
        drive(1, 1, 4'b1010, 4'b0110, 1, 0); tick();
        drive(1, 0, 4'b1111, 4'b1111, 0, 0); tick();
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_valid", bus.out_valid, 1'b0);
        check("rst_async_y", bus.out_y, '0);
        check("rst_async_zero", bus.out_zero, 1'b1);
        m_valid = 1'b0;
        m_y     = '0;
        m_acc   = '0;
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drive(1, 7, 4'b1001, '0, 1, 0);
        tick();
        check("post_rst_acc", bus.out_y, 4'b0000);
        drive(1, 1, 4'b1000, 4'b0001, 0, 0);
        tick();
        check("post_rst_or", bus.out_y, 4'b1001);

        // Randomised traffic; source holds values until accepted
        drive(0, 0, '0, '0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            if (!(bus.in_valid && !m_fire)) begin
                drive(($urandom_range(3) != 0), $urandom_range(7), W'($urandom),
                      W'($urandom), $urandom_range(1), 0);
            end
            bus.acc_clr   = ($urandom_range(7) == 0);
            bus.out_ready = ($urandom_range(3) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
        $finish;
    end

endmodule
